dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
// Direct-mapped, write-back, write-allocate data cache between the pipeline MEM stage
// (EX/MEM ALU address, store data, memread/memwrite) and a line-wide off-chip data memory.
// Hits complete in the access cycle with no stall. Misses assert cpu_stall_o, write back a
// dirty victim if needed, refill the line, then finish the access. The pipeline freezes all
// stages while cpu_stall_o=1.
// PARAMETERS
// NUM_LINES   32   number of cache lines (power of 2); index width IDX=log2(NUM_LINES)
// LINE_BITS   256  line width in bits (8 x 32-bit words); offset = addr[4:0], word = addr[4:2]
// PORTS
// clk_i        in   1          clock
// rst_i        in   1          reset, synchronous, active-high
// cpu_req_i    in   1          access valid (EX/MEM memread | memwrite)
// cpu_write_i  in   1          1=store, 0=load
// cpu_addr_i   in   32         byte address, word-aligned
// cpu_wdata_i  in   32         store data
// cpu_rdata_o  out  32         load data, valid on the cycle the access completes
// cpu_stall_o  out  1          1 = access not done; hold all pipeline registers
// mem_req_o    out  1          memory request, held until acknowledged
// mem_write_o  out  1          1=line write-back, 0=line fetch
// mem_addr_o   out  32         line address, low 5 bits zero
// mem_wdata_o  out  LINE_BITS  victim line data
// mem_ack_i    in   1          one-cycle acknowledge; fetch data valid in the same cycle
// mem_rdata_i  in   LINE_BITS  fetched line
// BEHAVIOUR
// - Address split: tag=addr[31:5+IDX], index=addr[4+IDX:5], word=addr[4:2].
// - Per-line state: valid, dirty, tag, data. Arrays are registers, not SRAM macros.
// - Reset: all valid/dirty clear, FSM=IDLE, mem_req_o=0, mem_write_o=0, cpu_stall_o=0,
//   cpu_rdata_o=0.
// - FSM states: IDLE, WB, FETCH, FILL.
// - IDLE, hit = req & valid & tag match.
//   - Hit: stall=0, and rdata=word is combinational.
//   - Store hit: write the word and set dirty at the clock edge.
// - IDLE, req & !hit: stall=1 combinationally.
//   - If victim valid & dirty -> WB. Otherwise -> FETCH.
// - WB: mem_req_o=1, mem_write_o=1, mem_addr_o={victim tag,index,5'b0}, mem_wdata_o=victim line.
//   On mem_ack_i -> FETCH.
// - FETCH: mem_req_o=1, mem_write_o=0, mem_addr_o={cpu tag,index,5'b0}.
//   - On mem_ack_i: store mem_rdata_i, valid=1, dirty=0, tag=cpu tag; -> FILL.
// - FILL: stall=1 for one cycle; -> IDLE. The access then hits and completes there.
//   A store merges and sets dirty on that hit.
// - Miss latency: 2 + ack wait cycles for a clean victim; the write-back adds its own ack wait.
// - mem_req_o/mem_write_o/mem_addr_o decode from state only and are stable while waiting.
//   mem_req_o drops the cycle after the ack.
// - mem_ack_i in IDLE or FILL is ignored.
// - The CPU holds cpu_* inputs stable while cpu_stall_o=1. Otherwise behaviour is undefined.
// - cpu_req_i=0 in IDLE: stall=0, rdata=0, no state change.
// - stall=0 whenever rst_i=1.
// - rst_i mid-transaction: abort at that edge. The next cycle is IDLE with mem_req_o=0 and
//   all lines invalid. Dirty data is discarded, and the memory side tolerates the dropped request.
// - Ack in the same cycle the request first rises is legal; the transition happens at that edge.
// TESTING
// 1 reset; load 0x40 -> stall=1; FETCH with addr 0x40, write=0. Ack after 3 cycles
//   (word0=0x11111111) -> FILL, then rdata=0x11111111 and stall=0. No write-back issued.
// 2 load 0x4C (same line) -> stall=0 same cycle, rdata=word3, mem_req_o stays 0.
// 3 store 0x44 <= 0xDEADBEEF -> no stall; next load 0x44 returns 0xDEADBEEF.
// 4 load 0x440 (index 2, new tag) -> WB with addr 0x40 and mem_wdata_o[63:32]=0xDEADBEEF.
//   After the ack, FETCH with addr 0x440. Then the completion hit, stall=0.
// 5 store miss to a clean line 0x1000 <= 0x5A5A5A5A -> FETCH only. Load 0x1000 then returns
//   0x5A5A5A5A. Evicting that line later issues a WB.
// 6 rst_i=1 during FETCH with ack pending -> next cycle mem_req_o=0 and stall=0.
//   A load to the previously filled 0x4C then misses.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage, with a line-wide memory port.
// Latency: a hit completes in the same cycle. A miss costs 2 cycles plus the fetch ack wait,
//          plus the write-back ack wait when the victim line is dirty.
// Backpressure: cpu_stall_o holds the pipeline until the access is done. mem_req_o stays asserted until mem_ack_i.
// Ports: cpu_* is the pipeline side (req/write/addr/wdata in, rdata/stall out).
//        mem_* is the line memory side (req/write/addr/wdata out, ack/rdata in).
module dcache_ctrl #(
    parameter int NUM_LINES = 32,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_write_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_wdata_i,
    output logic [31:0]          cpu_rdata_o,
    output logic                 cpu_stall_o,
    output logic                 mem_req_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_wdata_o,
    input  logic                 mem_ack_i,
    input  logic [LINE_BITS-1:0] mem_rdata_i
);

    localparam int IDX   = $clog2(NUM_LINES);
    localparam int TAG_W = 27 - IDX;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WB    = 2'd1;
    localparam logic [1:0] S_FETCH = 2'd2;
    localparam logic [1:0] S_FILL  = 2'd3;

    logic [1:0]           state_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    logic [TAG_W-1:0] cpu_tag;
    logic [IDX-1:0]   idx;
    logic [2:0]       word;
    logic             hit;
    logic             in_idle;
    logic             access_hit;
    logic             store_hit;
    logic             fetch_done;
    logic             unused_addr_lsb;

    assign cpu_tag = cpu_addr_i[31:5+IDX];
    assign idx     = cpu_addr_i[4+IDX:5];
    assign word    = cpu_addr_i[4:2];
    // Accesses are word-aligned, so the byte offset is never used.
    assign unused_addr_lsb = &{1'b0, cpu_addr_i[1:0]};

    assign hit        = valid_q[idx] && (tag_q[idx] == cpu_tag);
    assign in_idle    = (state_q == S_IDLE);
    // Gating with rst_i keeps reset from completing an access or writing the arrays.
    assign access_hit = !rst_i && in_idle && cpu_req_i && hit;
    assign store_hit  = access_hit && cpu_write_i;
    assign fetch_done = !rst_i && (state_q == S_FETCH) && mem_ack_i;

    assign cpu_rdata_o = access_hit ? data_q[idx][{word, 5'b0} +: 32] : 32'h0;
    // WB, FETCH and FILL always stall. FILL gives the refilled line one cycle
    // so the access can complete as an ordinary hit in IDLE.
    assign cpu_stall_o = !rst_i && (in_idle ? (cpu_req_i && !hit) : 1'b1);

    // The memory side decodes from state only. The inputs are frozen during a
    // miss, so idx and cpu_tag are stable while a request waits for its ack.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = '0;
        case (state_q)
            S_WB: begin
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                mem_addr_o  = {tag_q[idx], idx, 5'b0};
                mem_wdata_o = data_q[idx];
            end
            S_FETCH: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {cpu_tag, idx, 5'b0};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cpu_req_i && !hit) begin
                        state_q <= (valid_q[idx] && dirty_q[idx]) ? S_WB : S_FETCH;
                    end else if (store_hit) begin
                        dirty_q[idx] <= 1'b1;
                    end
                end
                S_WB: begin
                    if (mem_ack_i) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (mem_ack_i) begin
                        state_q      <= S_FILL;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The tag and data arrays need no reset. Lines are only read when valid.
    always_ff @(posedge clk_i) begin
        if (fetch_done) begin
            data_q[idx] <= mem_rdata_i;
            tag_q[idx]  <= cpu_tag;
        end else if (store_hit) begin
            data_q[idx][{word, 5'b0} +: 32] <= cpu_wdata_i;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios followed by random traffic.
// A cache-plus-memory model predicts each completion and memory transaction.
// A monitor checks them against the DUT as they appear.
module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         cpu_req_i = 1'b0;
    logic         cpu_write_i = 1'b0;
    logic [31:0]  cpu_addr_i = 32'h0;
    logic [31:0]  cpu_wdata_i = 32'h0;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic         mem_ack_i = 1'b0;
    logic [255:0] mem_rdata_i = '0;

    dcache_ctrl #(.NUM_LINES(32), .LINE_BITS(256)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
        .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct { bit wr; logic [31:0] data; } cpu_exp_t;
    typedef struct { bit wr; logic [31:0] addr; logic [255:0] data; } mem_exp_t;
    cpu_exp_t cpu_q[$];
    mem_exp_t mem_q[$];

    // Reference model: the cache contents and the backing memory image.
    bit           m_valid [32];
    bit           m_dirty [32];
    logic [21:0]  m_tag   [32];
    logic [255:0] m_data  [32];
    logic [255:0] mem_img [logic [26:0]];

    int fixed_dly = -1;
    bit hold = 1'b0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk256(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] mem_get(input logic [26:0] la);
        logic [255:0] r;
        if (mem_img.exists(la)) return mem_img[la];
        for (int j = 0; j < 8; j++) r[j*32 +: 32] = {la[23:0], 5'(j), 3'b101};
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        cpu_q.delete();
        mem_q.delete();
    endtask

    // Predicts the outcome of one access and pushes the expected events.
    task automatic predict(input bit wr, input logic [31:0] a, input logic [31:0] d);
        int          ix;
        int          w;
        logic [21:0] tg;
        mem_exp_t    me;
        cpu_exp_t    ce;
        ix = int'(a[9:5]);
        w  = int'(a[4:2]);
        tg = a[31:10];
        if (!(m_valid[ix] && m_tag[ix] == tg)) begin
            if (m_valid[ix] && m_dirty[ix]) begin
                me.wr = 1'b1; me.addr = {m_tag[ix], a[9:5], 5'b0}; me.data = m_data[ix];
                mem_q.push_back(me);
                mem_img[{m_tag[ix], a[9:5]}] = m_data[ix];
            end
            me.wr = 1'b0; me.addr = {tg, a[9:5], 5'b0}; me.data = '0;
            mem_q.push_back(me);
            m_data[ix]  = mem_get({tg, a[9:5]});
            m_valid[ix] = 1'b1;
            m_dirty[ix] = 1'b0;
            m_tag[ix]   = tg;
        end
        ce.wr = wr;
        ce.data = m_data[ix][w*32 +: 32];
        cpu_q.push_back(ce);
        if (wr) begin
            m_data[ix][w*32 +: 32] = d;
            m_dirty[ix] = 1'b1;
        end
    endtask

    // Issues one access (starting just after a posedge) and counts its stall cycles.
    task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d, output int stalls);
        predict(wr, a, d);
        cpu_req_i = 1'b1; cpu_write_i = wr; cpu_addr_i = a; cpu_wdata_i = d;
        stalls = 0;
        forever begin
            @(negedge clk_i);
            if (!cpu_stall_o) break;
            stalls++;
            if (stalls > 200) begin
                n_chk++; n_fail++;
                $display("FAIL access_timeout: addr %h still stalled after %0d cycles", a, stalls);
                break;
            end
        end
        @(posedge clk_i); #1;
        cpu_req_i = 1'b0;
    endtask

    // Memory responder: acknowledges each request after a delay.
    initial begin
        int cnt;
        cnt = -1;
        forever begin
            @(posedge clk_i); #1;
            mem_ack_i = 1'b0;
            if (rst_i || hold || !mem_req_o) begin
                cnt = -1;
            end else begin
                if (cnt < 0) cnt = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
                if (cnt == 0) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = mem_write_o ? 256'($urandom) : mem_get(mem_addr_o[31:5]);
                    cnt = -1;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: matches DUT completions and memory transactions against the scoreboard.
    initial begin
        cpu_exp_t ce;
        mem_exp_t me;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (!cpu_req_i) chk32("rdata_idle", cpu_rdata_o, 32'h0);
                if (cpu_req_i && !cpu_stall_o) begin
                    if (cpu_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL cpu_unexpected: completion at addr %h with nothing expected", cpu_addr_i);
                    end else begin
                        ce = cpu_q.pop_front();
                        if (!ce.wr) chk32("load_rdata", cpu_rdata_o, ce.data);
                    end
                end
                if (mem_req_o && mem_ack_i) begin
                    if (mem_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL mem_unexpected: request addr %h write %0b", mem_addr_o, mem_write_o);
                    end else begin
                        me = mem_q.pop_front();
                        chk32("mem_write", 32'(mem_write_o), 32'(me.wr));
                        chk32("mem_addr", mem_addr_o, me.addr);
                        if (me.wr) chk256("mem_wdata", mem_wdata_o, me.data);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        logic [255:0] l40;
        logic [31:0]  a;
        model_reset();
        for (int j = 0; j < 8; j++) l40[j*32 +: 32] = 32'h11111111 + 32'(j);
        mem_img[27'h2] = l40;

        // Reset state
        @(negedge clk_i);
        chk32("stall_in_reset", 32'(cpu_stall_o), 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk32("reset_stall", 32'(cpu_stall_o), 32'h0);
        chk32("reset_mem_req", 32'(mem_req_o), 32'h0);
        chk32("reset_mem_write", 32'(mem_write_o), 32'h0);
        chk32("reset_rdata", cpu_rdata_o, 32'h0);
        @(posedge clk_i); #1;

        // 1: cold load miss with ack after 3 cycles: 1 IDLE + 4 FETCH + 1 FILL stall cycles
        fixed_dly = 3;
        access(1'b0, 32'h40, 32'h0, st);
        chk32("t1_stall_cycles", st, 32'd6);
        fixed_dly = -1;

        // 2: same line -> hit
        access(1'b0, 32'h4C, 32'h0, st);
        chk32("t2_hit_stall", st, 32'd0);

        // 3: store hit then load back
        access(1'b1, 32'h44, 32'hDEADBEEF, st);
        chk32("t3_store_stall", st, 32'd0);
        access(1'b0, 32'h44, 32'h0, st);
        chk32("t3_load_stall", st, 32'd0);

        // 4: conflict miss evicts the dirty line (model predicts WB 0x40 then FETCH 0x440)
        access(1'b0, 32'h440, 32'h0, st);

        // 5: store miss to clean line, reload, then evict it
        access(1'b1, 32'h1000, 32'h5A5A5A5A, st);
        access(1'b0, 32'h1000, 32'h0, st);
        chk32("t5_load_hit_stall", st, 32'd0);
        access(1'b0, 32'h2000, 32'h0, st);

        // 6: reset while FETCH waits for its ack
        hold = 1'b1;
        predict(1'b0, 32'h4000, 32'h0);
        cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h4000;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk32("t6_fetch_req", 32'(mem_req_o), 32'h1);
        chk32("t6_fetch_write", 32'(mem_write_o), 32'h0);
        chk32("t6_fetch_addr", mem_addr_o, 32'h4000);
        @(posedge clk_i); #1;
        rst_i = 1'b1; cpu_req_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        chk32("t6_stall_in_reset", 32'(cpu_stall_o), 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b0; hold = 1'b0;
        @(negedge clk_i);
        chk32("t6_mem_req_after_reset", 32'(mem_req_o), 32'h0);
        chk32("t6_stall_after_reset", 32'(cpu_stall_o), 32'h0);
        @(posedge clk_i); #1;
        access(1'b0, 32'h4C, 32'h0, st);
        n_chk++;
        if (st == 0) begin
            n_fail++;
            $display("FAIL t6_reload_miss: got %0d stall cycles expected more than 0", st);
        end

        // Random traffic over a few tags and indices, so conflicts and evictions are frequent
        for (int i = 0; i < 400; i++) begin
            a = {20'h0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'b00};
            access(1'($urandom_range(0, 1)), a, $urandom, st);
        end

        repeat (4) @(posedge clk_i);
        chk32("cpu_queue_drained", 32'(cpu_q.size()), 32'h0);
        chk32("mem_queue_drained", 32'(mem_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
